// File: rtl/mem_responder_pipe.sv
// mem_responder_pipe
// -----------------------------------------------------------------------------
// Pipelined, fixed-latency data-memory responder. It accepts one request per
// cycle on the CPU data-memory interface and has no backpressure. A write
// updates the storage array on the same edge that accepts it. A read samples
// the array on its accept edge and returns the word exactly LATENCY cycles
// later, with a one-cycle data_valid strobe. Responses come back strictly in
// request order.
//
// Build option:
//   MEMRESP_WRITE_ACK_EN - when defined, each accepted write produces a wr_ack
//                          strobe LATENCY cycles later and counts toward
//                          `outstanding`. When undefined, wr_ack is tied low
//                          and writes are fire-and-forget.
//
// Parameters:
//   ADDR_WIDTH  word-address bits; the array holds 2^ADDR_WIDTH 16-bit words
//   LATENCY     read latency in cycles, 1..8
//
// Ports:
//   clk          sole clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   enable       a request is present this cycle
//   wr           1 = write, 0 = read (ignored when enable = 0)
//   addr         byte address; the word index is addr[ADDR_WIDTH:1]
//   data_in      write data
//   data_out     returned read data; holds the last returned value
//   data_valid   one-cycle strobe that marks returned read data
//   wr_ack       one-cycle write-completion strobe (build option only)
//   outstanding  accepted requests that have not completed yet
// -----------------------------------------------------------------------------
module mem_responder_pipe #(
  parameter int ADDR_WIDTH = 13,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        wr_ack,
  output logic [3:0]  outstanding
);

`ifdef MEMRESP_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  // The last pipeline stage is the output register set (data_valid, wr_ack,
  // data_out). The internal shift register therefore needs only LATENCY-1
  // stages. One stage is kept as a minimum so that the arrays stay legal
  // when LATENCY is 1.
  localparam int PDEPTH = (LATENCY > 1) ? LATENCY - 1 : 1;

  logic [15:0]           mem [0:(1 << ADDR_WIDTH) - 1];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;

  logic [PDEPTH-1:0]     pipe_valid;
  logic [PDEPTH-1:0]     pipe_write;
  logic [15:0]           pipe_data [0:PDEPTH-1];

  logic [LATENCY-1:0]    in_valid;
  logic [LATENCY-1:0]    in_write;
  logic [15:0]           in_data [0:LATENCY-1];

  logic                  count_up;
  logic                  count_down;

  // The byte-select bit and the address bits above the word index are not
  // used for decoding. That is what makes 0x0010/0x0011 alias and makes the
  // upper bits wrap.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^{addr[15:ADDR_WIDTH+1], addr[0]};

  assign word_idx = addr[ADDR_WIDTH:1];

  // A request that arrives in the same cycle as reset is dropped completely,
  // including its write to the array.
  assign accept = enable & ~rst;

  // Storage array. It has no reset, so contents survive rst. A write lands on
  // its accept edge, so a read accepted on the next edge already sees it.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[word_idx] <= data_in;
    end
  end

  // Inputs to each pipeline stage. Stage 0 is fed by the current request.
  // Every later stage is fed by the stage before it.
  // Write entries also carry the array word, and nothing ever consumes it.
  // This keeps the read port free of muxing so that it maps onto a
  // registered-read RAM.
  always_comb begin
    in_valid[0] = accept;
    in_write[0] = wr;
    in_data[0]  = mem[word_idx];
    for (int i = 1; i < LATENCY; i++) begin
      in_valid[i] = pipe_valid[i-1];
      in_write[i] = pipe_write[i-1];
      in_data[i]  = pipe_data[i-1];
    end
  end

  // Valid bits are the only pipeline state that reset must clear. Clearing
  // them drops every in-flight request, so none of them ever strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      for (int i = 0; i < LATENCY - 1; i++) begin
        pipe_valid[i] <= in_valid[i];
      end
    end
  end

  // Payload stages shift every cycle. Their contents matter only while the
  // matching valid bit is set, so they have no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY - 1; i++) begin
      pipe_write[i] <= in_write[i];
      pipe_data[i]  <= in_data[i];
    end
  end

  // Final stage for read data. data_out loads only when a read completes, so
  // it holds the last returned word between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      data_out   <= 16'h0000;
    end else begin
      data_valid <= in_valid[LATENCY-1] & ~in_write[LATENCY-1];
      if (in_valid[LATENCY-1] && !in_write[LATENCY-1]) begin
        data_out <= in_data[LATENCY-1];
      end
    end
  end

`ifdef MEMRESP_WRITE_ACK_EN
  // Write completion leaves the same stage as read data. Only one request
  // occupies each stage, so data_valid and wr_ack can never be high together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= in_valid[LATENCY-1] & in_write[LATENCY-1];
    end
  end
`else
  assign wr_ack = 1'b0;
`endif

  // A request is counted from the cycle after it is accepted until the end of
  // its completion-strobe cycle. Writes count only when they are acknowledged.
  // The count can never exceed LATENCY, because each pipeline stage holds at
  // most one request.
  assign count_up   = accept & (~wr | ACK_EN);
  assign count_down = data_valid | wr_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= 4'd0;
    end else if (count_up && !count_down) begin
      outstanding <= outstanding + 4'd1;
    end else if (!count_up && count_down) begin
      outstanding <= outstanding - 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_responder_pipe.sv
// tb_mem_responder_pipe
// -----------------------------------------------------------------------------
// Testbench for mem_responder_pipe with LATENCY = 4.
//
// Cycle numbering: applyStimulus drives one cycle's inputs and steps past the
// rising edge. The outputs observed right after that are those of the next
// cycle.
//
// The reference model is an array of words plus a queue of pending
// completions, each tagged with the cycle in which it must strobe.
// It covers both builds; MEMRESP_WRITE_ACK_EN selects the write-ack behaviour.
// -----------------------------------------------------------------------------
module tb_mem_responder_pipe;

  localparam int AW = 13;
  localparam int L  = 4;

`ifdef MEMRESP_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        wr_ack;
  logic [3:0]  outstanding;

  int errors = 0;
  int checks = 0;

  mem_responder_pipe #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .wr          (wr),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .wr_ack      (wr_ack),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int          due;
    bit          is_wr;
    logic [15:0] data;
  } ev_t;

  logic [15:0] mmem [0:(1 << AW) - 1];
  ev_t         evq[$];
  int          cyc = 0;
  logic [15:0] m_last = 16'h0000;
  bit          e_valid;
  bit          e_ack;
  logic [15:0] e_dout;
  int          e_out;

  // Table vector:
  //   inputs
  //   expected outputs in the following cycle
  //   wr_ack expectation as seen in the ack build
  //   outstanding for each build
  typedef struct {
    bit          r;
    bit          en;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    bit          ev;
    bit          eack;
    logic [15:0] edout;
    int          eout_ack;
    int          eout_noack;
  } vec_t;

  vec_t tabA [6];
  vec_t tabB [8];

  // Drive one cycle, step the model with the same request, advance past the
  // clock edge and compute what the outputs must show in the new cycle.
  task automatic applyStimulus(input bit r, input bit en, input bit w,
                               input logic [15:0] a, input logic [15:0] d);
    int  idx;
    ev_t ev;
    rst     = r;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    idx = int'(a[AW:1]);
    if (r) begin
      evq.delete();
      m_last = 16'h0000;
    end else if (en) begin
      ev.due   = cyc + L;
      ev.is_wr = w;
      ev.data  = mmem[idx];
      if (w) mmem[idx] = d;
      if (!w || ACK) evq.push_back(ev);
    end
    @(posedge clk);
    #1;
    cyc++;
    while (evq.size() > 0 && evq[0].due < cyc) void'(evq.pop_front());
    e_valid = 1'b0;
    e_ack   = 1'b0;
    if (evq.size() > 0 && evq[0].due == cyc) begin
      if (evq[0].is_wr) begin
        e_ack = 1'b1;
      end else begin
        e_valid = 1'b1;
        m_last  = evq[0].data;
      end
    end
    e_dout = m_last;
    e_out  = evq.size();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%04h, expected 0x%04h",
               name, cyc, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " data_valid"}, {15'b0, data_valid}, {15'b0, e_valid});
    checkOutput({tag, " wr_ack"}, {15'b0, wr_ack}, {15'b0, e_ack});
    checkOutput({tag, " data_out"}, data_out, e_dout);
    checkOutput({tag, " outstanding"}, {12'b0, outstanding}, 16'(e_out));
    checkOutput({tag, " strobes exclusive"}, {15'b0, data_valid & wr_ack}, 16'h0000);
  endtask

  task automatic idle(input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      if (chk) checkModel("idle");
    end
  endtask

  task automatic applyVec(input vec_t v, input string name);
    applyStimulus(v.r, v.en, v.w, v.a, v.d);
    checkOutput({name, " data_valid"}, {15'b0, data_valid}, {15'b0, v.ev});
    checkOutput({name, " wr_ack"}, {15'b0, wr_ack}, {15'b0, v.eack & ACK});
    checkOutput({name, " data_out"}, data_out, v.edout);
    checkOutput({name, " outstanding"}, {12'b0, outstanding},
                16'(ACK ? v.eout_ack : v.eout_noack));
  endtask

  // Issue a read now and require exactly one strobe carrying `exp`, LATENCY
  // cycles later.
  task automatic readExpect(input logic [15:0] a, input logic [15:0] exp,
                            input string name);
    applyStimulus(1'b0, 1'b1, 1'b0, a, 16'h0000);
    checkModel(name);
    idle(L - 1, 1'b1);
    checkOutput({name, " strobe"}, {15'b0, data_valid}, 16'h0001);
    checkOutput({name, " value"}, data_out, exp);
  endtask

  initial begin
    // Write then read of word 0x10; the write also drives wr_ack in the ack build
    tabA[0] = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0000, 1, 0};
    tabA[1] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 2, 1};
    tabA[2] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2, 1};
    tabA[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 2, 1};
    tabA[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 1, 1};
    tabA[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234, 0, 0};
    // Four back-to-back reads; data_out holds 0x1234 until the first strobe
    tabB[0] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h1234, 1, 1};
    tabB[1] = '{1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000, 1'b0, 1'b0, 16'h1234, 2, 2};
    tabB[2] = '{1'b0, 1'b1, 1'b0, 16'h0024, 16'h0000, 1'b0, 1'b0, 16'h1234, 3, 3};
    tabB[3] = '{1'b0, 1'b1, 1'b0, 16'h0026, 16'h0000, 1'b1, 1'b0, 16'hA000, 4, 4};
    tabB[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hA001, 3, 3};
    tabB[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hA002, 2, 2};
    tabB[6] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hA003, 1, 1};
    tabB[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hA003, 0, 0};

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("reset data_valid", {15'b0, data_valid}, 16'h0000);
    checkOutput("reset wr_ack", {15'b0, wr_ack}, 16'h0000);
    checkOutput("reset data_out", data_out, 16'h0000);
    checkOutput("reset outstanding", {12'b0, outstanding}, 16'h0000);

    // Give the first 64 words known contents before anything reads them
    for (int w = 0; w < 64; w++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 16'(w << 1), 16'h5A00 ^ 16'(w));
    end
    idle(L + 2, 1'b1);

    for (int i = 0; i < 6; i++) applyVec(tabA[i], $sformatf("tabA[%0d]", i));

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020 + 16'(2 * i), 16'hA000 + 16'(i));
    end
    idle(L + 2, 1'b1);

    for (int i = 0; i < 8; i++) applyVec(tabB[i], $sformatf("tabB[%0d]", i));

    // Reset while three reads are in flight. The write presented with rst
    // must be dropped as well.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    checkModel("pre-reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
    checkModel("pre-reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0024, 16'h0000);
    checkModel("pre-reset");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0020, 16'h5555);
    checkOutput("mid reset data_out", data_out, 16'h0000);
    checkOutput("mid reset outstanding", {12'b0, outstanding}, 16'h0000);
    for (int i = 0; i < L + 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      checkOutput("dropped read no strobe", {15'b0, data_valid}, 16'h0000);
      checkOutput("dropped read outstanding", {12'b0, outstanding}, 16'h0000);
    end
    readExpect(16'h0020, 16'hA000, "array kept over reset");

    // Read of the old value, followed by an overwrite in the next cycle
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040, 16'h1111);
    idle(L + 2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    checkModel("rw");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040, 16'h2222);
    checkModel("rw");
    idle(2, 1'b1);
    checkOutput("read-before-write strobe", {15'b0, data_valid}, 16'h0001);
    checkOutput("read-before-write old data", data_out, 16'h1111);
    idle(2, 1'b1);
    readExpect(16'h0040, 16'h2222, "later read new data");

    // addr[0] aliasing and wrap of the upper address bits
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    readExpect(16'h0011, 16'hBEEF, "addr[0] alias");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hC010, 16'hC0DE);
    readExpect(16'h0010, 16'hC0DE, "upper bits wrap");
    idle(L + 2, 1'b1);

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)),
                    {2'($urandom_range(0, 3)), 7'b0, 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1))},
                    16'($urandom));
      checkModel("rand");
    end
    idle(L + 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder_pipe.md
# mem_responder_pipe

Pipelined, fixed-latency data-memory responder for the CPU's data-memory request interface (enable / wr / addr / data_in). It accepts one request per cycle, commits writes immediately, and returns read data exactly LATENCY cycles later with a one-cycle valid strobe. It replaces the single-cycle data memory for the multi-cycle memory phase of the processor.

## Interface
- ADDR_WIDTH, 13, word-address bits; storage is 2^ADDR_WIDTH 16-bit words.
- LATENCY, 4, read latency in cycles; legal range 1..8.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  request present this cycle.
- wr  in  1  1 = write, 0 = read; ignored when enable=0.
- addr  in  16  byte address; word index = addr[ADDR_WIDTH:1]; addr[0] and bits above ADDR_WIDTH ignored.
- data_in  in  16  write data.
- data_out  out  16  read data; valid only while data_valid=1.
- data_valid  out  1  one-cycle strobe marking returned read data.
- wr_ack  out  1  one-cycle write-completion strobe (see Configuration).
- outstanding  out  4  number of accepted requests not yet completed.

## Operation
- No backpressure: every cycle with enable=1 is an accepted request.
- Read accepted at edge T: array word sampled at edge T, shifted through a LATENCY-deep pipeline of {valid, is_write, data} stages.
- Write accepted at edge T: array word updated at edge T; pipeline stage carries is_write=1, no data.
- Reads return strictly in request order; no reordering, no merging.
- Address aliasing: 0x0010 and 0x0011 hit the same word; upper unused bits wrap.
- outstanding: +1 on each counted accept, -1 on each completion strobe; accept and completion in the same cycle leaves it unchanged. Max value LATENCY; never wraps.
- Counted accepts: reads always; writes only when wr_ack is enabled.
- data_out holds last returned read value between strobes.
- Reset: pipeline valid bits cleared, data_out=0, data_valid=0, wr_ack=0, outstanding=0. Array contents are not cleared.
- Reset mid-operation: all in-flight requests dropped; no strobe is ever produced for them. A request presented in the same cycle as rst=1 is ignored, including writes.

## Timing
- Read issued (enable=1, wr=0) in cycle T → data_valid=1 and data_out=word in cycle T+LATENCY, for exactly one cycle.
- Back-to-back reads in T, T+1, ... → strobes in T+LATENCY, T+LATENCY+1, ..., with no gaps.
- Write in T, read of same word in T+1 → read returns the written data (write-then-read forwarding through the array; no hazard).
- Read in T, write of same word in T+1 → read returns old data.
- Write completion, when enabled: wr_ack=1 in cycle T+LATENCY.
- data_valid and wr_ack are never high in the same cycle.

## Configuration
- MEMRESP_WRITE_ACK_EN defined: wr_ack pulses LATENCY cycles after each accepted write; writes count in outstanding.
- Undefined: wr_ack tied to 0; writes are fire-and-forget and do not count in outstanding. Read behaviour is identical in both builds.

## Test plan
- LATENCY=4: write 0x1234 to addr 0x0010 in cycle 0, read 0x0010 in cycle 1 → data_valid=1, data_out=0x1234 in cycle 5 only.
- Preload words 0x20/0x22/0x24/0x26 with 0xA000..0xA003; reads in cycles 0-3 → strobes cycles 4-7 with 0xA000..0xA003 in order; outstanding peaks at 4, returns to 0 in cycle 8.
- Read 0x0011 after writing 0xBEEF to 0x0010 → returns 0xBEEF (addr[0] ignored).
- Reads issued in cycles 0-2, rst=1 in cycle 3 → no data_valid ever; data_out=0, outstanding=0 after reset; earlier-written array data still readable.
- Read 0x0040 (old 0x1111) in cycle 0, write 0x2222 to 0x0040 in cycle 1 → cycle-4 strobe returns 0x1111; later read returns 0x2222.
- MEMRESP_WRITE_ACK_EN defined: write in cycle 0, read in cycle 1 → wr_ack in cycle 4, data_valid in cycle 5, outstanding 1→2→1→0; undefined build: wr_ack stays 0, outstanding only 1 during read.
